// File: rtl/ru_pkg.sv
// rtl/ru_pkg.sv - shared types, defaults and helpers for the recompute unit engine
package ru_pkg;

    // Engine FSM encoding; the top maps these onto plain 2-bit state constants.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } ru_state_e;

    localparam int RU_DATA_W = 8;
    localparam int RU_K      = 4;
    // Full-precision product plus log2(K) growth plus one spare bit: cannot overflow.
    localparam int RU_ACC_W  = 2 * RU_DATA_W + $clog2(RU_K) + 1;

    // Index width for a dimension of size n; never narrower than one bit.
    function automatic int ru_clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ru_mac.sv
// rtl/ru_mac.sv - signed multiply-accumulate register with clear and enable
module ru_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 19
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;

    assign prod     = a * b;
    assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};

    // Accumulator: clear wins over enable so a new command always starts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/recompute_unit_engine.sv
// rtl/recompute_unit_engine.sv - recomputes one faulty systolic-array output element per command
// Optional build macro RU_RANGE_CHECK_EN adds res_err and an out-of-range command bypass.
module recompute_unit_engine
    import ru_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int K      = RU_K,
    parameter int DATA_W = RU_DATA_W,
    parameter int RW     = ru_clog2_min1(ROWS),
    parameter int CW     = ru_clog2_min1(COLS),
    parameter int KW     = ru_clog2_min1(K),
    parameter int ACC_W  = 2 * DATA_W + $clog2(K) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [RW-1:0]            cmd_row,
    input  logic [CW-1:0]            cmd_col,
    output logic                     op_req_valid,
    input  logic                     op_req_ready,
    output logic [RW-1:0]            op_req_row,
    output logic [CW-1:0]            op_req_col,
    output logic [KW-1:0]            op_req_k,
    input  logic                     op_rsp_valid,
    input  logic signed [DATA_W-1:0] op_rsp_data,
    input  logic signed [DATA_W-1:0] op_rsp_weight,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [RW-1:0]            res_row,
    output logic [CW-1:0]            res_col,
    output logic signed [ACC_W-1:0]  res_value,
    output logic                     busy,
    output logic                     err_rsp
`ifdef RU_RANGE_CHECK_EN
    ,
    output logic                     res_err
`endif
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_DONE  = DONE;
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);

    logic [1:0]    state;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [KW-1:0] k_q;
    logic          err_q;
    logic          cmd_fire;
    logic          rsp_fire;
    logic          cmd_bad;

    assign cmd_fire = (state == ST_IDLE) && cmd_valid;
    assign rsp_fire = (state == ST_WAIT) && op_rsp_valid;

`ifdef RU_RANGE_CHECK_EN
    logic res_err_q;

    assign cmd_bad = (int'(cmd_row) >= ROWS) || (int'(cmd_col) >= COLS);
    assign res_err = res_err_q;

    // Error tag for the pending result, captured with the command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_err_q <= 1'b0;
        end else if (cmd_fire) begin
            res_err_q <= cmd_bad;
        end
    end
`else
    assign cmd_bad = 1'b0;
`endif

    // Handshake-side outputs are pure state decodes or registers.
    assign cmd_ready    = (state == ST_IDLE);
    assign op_req_valid = (state == ST_ISSUE);
    assign res_valid    = (state == ST_DONE);
    assign busy         = (state != ST_IDLE);
    assign op_req_row   = row_q;
    assign op_req_col   = col_q;
    assign op_req_k     = k_q;
    assign res_row      = row_q;
    assign res_col      = col_q;
    assign err_rsp      = err_q;

    ru_mac #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk(clk),
        .rst(rst),
        .clr(cmd_fire),
        .en (rsp_fire),
        .a  (op_rsp_data),
        .b  (op_rsp_weight),
        .acc(res_value)
    );

    // Command FSM: one request outstanding, k advances only on an accepted response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            row_q <= '0;
            col_q <= '0;
            k_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        row_q <= cmd_row;
                        col_q <= cmd_col;
                        k_q   <= '0;
                        state <= cmd_bad ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (op_req_ready) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (op_rsp_valid) begin
                        if (k_q == K_LAST) begin
                            state <= ST_DONE;
                        end else begin
                            k_q   <= k_q + KW'(1);
                            state <= ST_ISSUE;
                        end
                    end
                end
                default: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Sticky flag for any response that arrives when none is expected.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (op_rsp_valid && (state != ST_WAIT)) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_recompute_unit_engine.sv
// tb/tb_recompute_unit_engine.sv - directed self-checking bench for recompute_unit_engine
module tb_recompute_unit_engine;

`ifdef RU_RANGE_CHECK_EN
    localparam int ROWS = 3;
`else
    localparam int ROWS = 4;
`endif
    localparam int COLS   = 4;
    localparam int K      = 4;
    localparam int DATA_W = 8;
    localparam int RW     = 2;
    localparam int CW     = 2;
    localparam int KW     = 2;
    localparam int ACC_W  = 2 * DATA_W + 2 + 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [RW-1:0]            cmd_row;
    logic [CW-1:0]            cmd_col;
    logic                     op_req_valid;
    logic                     op_req_ready;
    logic [RW-1:0]            op_req_row;
    logic [CW-1:0]            op_req_col;
    logic [KW-1:0]            op_req_k;
    logic                     op_rsp_valid;
    logic signed [DATA_W-1:0] op_rsp_data;
    logic signed [DATA_W-1:0] op_rsp_weight;
    logic                     res_valid;
    logic                     res_ready;
    logic [RW-1:0]            res_row;
    logic [CW-1:0]            res_col;
    logic signed [ACC_W-1:0]  res_value;
    logic                     busy;
    logic                     err_rsp;
`ifdef RU_RANGE_CHECK_EN
    logic                     res_err;
`endif

    int checks   = 0;
    int failures = 0;
    logic signed [DATA_W-1:0] dvec [4];
    logic signed [DATA_W-1:0] wvec [4];
    bit pend;
    int pend_k;
    bit abort_now;

    always #5 clk = ~clk;

    recompute_unit_engine #(
        .ROWS(ROWS), .COLS(COLS), .K(K), .DATA_W(DATA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_row      (cmd_row),
        .cmd_col      (cmd_col),
        .op_req_valid (op_req_valid),
        .op_req_ready (op_req_ready),
        .op_req_row   (op_req_row),
        .op_req_col   (op_req_col),
        .op_req_k     (op_req_k),
        .op_rsp_valid (op_rsp_valid),
        .op_rsp_data  (op_rsp_data),
        .op_rsp_weight(op_rsp_weight),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_row      (res_row),
        .res_col      (res_col),
        .res_value    (res_value),
        .busy         (busy),
        .err_rsp      (err_rsp)
`ifdef RU_RANGE_CHECK_EN
        ,
        .res_err      (res_err)
`endif
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_vec(input int d0, d1, d2, d3, w0, w1, w2, w3);
        dvec[0] = DATA_W'(d0); dvec[1] = DATA_W'(d1); dvec[2] = DATA_W'(d2); dvec[3] = DATA_W'(d3);
        wvec[0] = DATA_W'(w0); wvec[1] = DATA_W'(w1); wvec[2] = DATA_W'(w2); wvec[3] = DATA_W'(w3);
    endtask

    // Called at a negedge with the engine idle; returns just after the result handshake edge.
    task automatic run_cmd(input int r, input int c, input int expv, input int stall_k,
                           input int stall_n, input int res_hold, input bit keep_valid,
                           input int nr, input int nc);
        int cyc, nreq, stall, hold, rk;
        bit rp, done, seen;
        cyc = 0; nreq = 0; stall = 0; hold = 0; rk = 0; rp = 0; done = 0; seen = 0;
        cmd_valid = 1'b1;
        cmd_row   = RW'(r);
        cmd_col   = CW'(c);
        chk("cmd_ready_idle", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
        if (keep_valid) begin
            cmd_row = RW'(nr);
            cmd_col = CW'(nc);
        end else begin
            cmd_valid = 1'b0;
        end
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            op_rsp_valid  = rp;
            op_rsp_data   = dvec[rk];
            op_rsp_weight = wvec[rk];
            rp = 1'b0;
            op_req_ready = 1'b1;
            res_ready    = 1'b0;
            chk("cmd_ready_busy", 32'(cmd_ready), 0);
            if (op_req_valid) begin
                chk("req_row", 32'(op_req_row), r);
                chk("req_col", 32'(op_req_col), c);
                chk("req_k", 32'(op_req_k), nreq);
                if (nreq == stall_k && stall < stall_n) begin
                    op_req_ready = 1'b0;
                    stall++;
                end else begin
                    rp = 1'b1;
                    rk = nreq;
                    nreq++;
                end
            end
            if (res_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency", cyc, 2 * K + 1 + stall_n);
                    chk("req_count", nreq, K);
                end
                chk("res_value", 32'(res_value), expv);
                chk("res_row", 32'(res_row), r);
                chk("res_col", 32'(res_col), c);
`ifdef RU_RANGE_CHECK_EN
                chk("res_err_valid_cmd", 32'(res_err), 0);
`endif
                if (hold < res_hold) begin
                    hold++;
                end else begin
                    res_ready = 1'b1;
                    done = 1'b1;
                end
            end
            @(posedge clk);
        end
        if (!done) chk("result_timeout", 0, 1);
        #1;
        res_ready    = 1'b0;
        op_rsp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_row = '0; cmd_col = '0;
        op_req_ready = 1'b0; op_rsp_valid = 1'b0; op_rsp_data = '0; op_rsp_weight = '0;
        res_ready = 1'b0;
        set_vec(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_req_valid", 32'(op_req_valid), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err_rsp", 32'(err_rsp), 0);
        chk("rst_res_value", 32'(res_value), 0);
        chk("rst_req_k", 32'(op_req_k), 0);
        rst = 1'b1;

        // Stray response while idle: sticky error, accumulator untouched.
        @(negedge clk);
        op_rsp_valid = 1'b1; op_rsp_data = 8'sd50; op_rsp_weight = 8'sd50;
        @(negedge clk);
        op_rsp_valid = 1'b0;
        chk("err_rsp_set", 32'(err_rsp), 1);
        chk("idle_acc_untouched", 32'(res_value), 0);
        chk("idle_not_busy", 32'(busy), 0);

        // Basic dot product: 5+12+21+32 = 70.
        set_vec(1, 2, 3, 4, 5, 6, 7, 8);
        @(negedge clk);
        run_cmd(2, 1, 70, -1, 0, 0, 1'b0, 0, 0);
        @(negedge clk);
        chk("err_rsp_sticky", 32'(err_rsp), 1);
        chk("post_res_valid", 32'(res_valid), 0);

        // Signed extremes, with the next command already waiting: 16384-16256+16129-1.
        set_vec(-128, -128, 127, 1, -128, 127, 127, -1);
        run_cmd(1, 3, 16256, -1, 0, 0, 1'b1, 3, 2);
        // Back-to-back command accepted right after the result handshake, with back-pressure:
        // 30-60+90+120 = 180.
        set_vec(10, -20, 30, -40, 3, 3, 3, -3);
        @(negedge clk);
        run_cmd(3, 2, 180, 2, 3, 5, 1'b0, 0, 0);
        @(negedge clk);
        chk("bp_single_result", 32'(res_valid), 0);
        chk("bp_idle_ready", 32'(cmd_ready), 1);

        // Reset while waiting for the k=2 response.
        set_vec(5, 5, 5, 5, 5, 5, 5, 5);
        cmd_valid = 1'b1; cmd_row = 2'd1; cmd_col = 2'd1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        pend = 1'b0; pend_k = 0; abort_now = 1'b0;
        for (int i = 0; i < 20 && !abort_now; i++) begin
            @(negedge clk);
            op_rsp_valid = pend; op_rsp_data = dvec[pend_k]; op_rsp_weight = wvec[pend_k];
            pend = 1'b0;
            op_req_ready = 1'b1;
            if (op_req_valid) begin
                pend = 1'b1;
                pend_k = int'(op_req_k);
                if (op_req_k == 2'd2) abort_now = 1'b1;
            end
            @(posedge clk);
        end
        chk("abort_reached_k2", 32'(abort_now), 1);
        @(negedge clk);
        op_rsp_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_cmd_ready", 32'(cmd_ready), 1);
        chk("abort_req_valid", 32'(op_req_valid), 0);
        chk("abort_req_row", 32'(op_req_row), 0);
        chk("abort_req_k", 32'(op_req_k), 0);
        chk("abort_res_value", 32'(res_value), 0);
        chk("abort_err_clear", 32'(err_rsp), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_replay_req", 32'(op_req_valid), 0);
            chk("no_replay_res", 32'(res_valid), 0);
        end
        set_vec(1, 1, 1, 1, 1, 1, 1, 1);
        run_cmd(0, 0, 4, -1, 0, 0, 1'b0, 0, 0);

`ifdef RU_RANGE_CHECK_EN
        // Out-of-range row bypasses the operand buffer entirely.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_row = 2'd3; cmd_col = 2'd0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        abort_now = 1'b0;
        for (int i = 0; i < 5 && !abort_now; i++) begin
            @(negedge clk);
            op_req_ready = 1'b1;
            chk("range_no_req", 32'(op_req_valid), 0);
            if (res_valid) begin
                abort_now = 1'b1;
                chk("range_res_value", 32'(res_value), 0);
                chk("range_res_err", 32'(res_err), 1);
                chk("range_res_row", 32'(res_row), 3);
                res_ready = 1'b1;
            end
            @(posedge clk);
        end
        chk("range_result_seen", 32'(abort_now), 1);
        #1 res_ready = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
